craft_serial_ctrl: RTL
======================

CRAFT_SERIAL_CTRL -- requirements
Module: craft_serial_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request to begin one encryption; sampled only in IDLE.
REQ-005 Port: stall  input  1  freezes all counters, state and reg_en while high.
REQ-006 Port: busy  output  1  high in LOAD, ROUND and OUT states.
REQ-007 Port: done  output  1  one-cycle pulse after the final output nibble.
REQ-008 Port: reg_en  output  1  enable to the key register and state datapath.
REQ-009 Port: ck0  output  1  load-select to the key register; high only in LOAD.
REQ-010 Port: r  output  8  current round index, 0..31, zero-extended.
REQ-011 Port: nib  output  4  nibble index within the current phase, 0..15.
REQ-012 Port: key_sel  output  2  tweakey selector, always equal to r[1:0].
REQ-013 Port: last_round  output  1  high while r == 31 in ROUND (final round skips MixColumn/permutation).
REQ-014 Port: out_valid  output  1  high in OUT when not stalled; nib identifies the ciphertext nibble.
REQ-015 Parameter: ROUNDS, default 32, number of cipher rounds.
REQ-016 Parameter: NIBBLES, default 16, nibbles per 64-bit block.

Function
REQ-017 States SHALL be IDLE, LOAD, ROUND, OUT and DONE, each one-hot or encoded, with no other reachable state.
REQ-018 IDLE -> LOAD SHALL occur on the edge where start = 1 and stall = 0; start in any other state SHALL be ignored.
REQ-019 LOAD SHALL last NIBBLES unstalled cycles with nib counting 0..15, r = 0, ck0 = 1 and reg_en = 1.
REQ-020 LOAD -> ROUND SHALL occur when nib == 15, with nib wrapping to 0.
REQ-021 ROUND SHALL last ROUNDS x NIBBLES unstalled cycles; nib counts 0..15 and r increments by 1 when nib wraps 15 -> 0.
REQ-022 ROUND -> OUT SHALL occur when r == 31 and nib == 15, with r holding 31 in OUT.
REQ-023 OUT SHALL last NIBBLES unstalled cycles with out_valid = 1, then move to DONE.
REQ-024 DONE SHALL last exactly one cycle with done = 1 and busy = 0, then return to IDLE with r and nib cleared to 0.
REQ-025 An unstalled run SHALL keep busy high for exactly 16 + 512 + 16 = 544 cycles.
REQ-026 While stall = 1: state, r and nib SHALL hold; reg_en and out_valid SHALL be 0; ck0, last_round and key_sel SHALL keep their values.
REQ-027 Stall asserted in DONE SHALL NOT extend the done pulse beyond one cycle.
REQ-028 Stall asserted in IDLE SHALL block start acceptance.
REQ-029 In IDLE: reg_en, ck0, out_valid, done, busy and last_round SHALL be 0.

Reset
REQ-030 Asserting reset_n low SHALL, asynchronously, force IDLE with r = 0, nib = 0 and all 1-bit outputs 0, including mid-run.
REQ-031 After deassertion, the first start SHALL be accepted on the next rising edge at the earliest.

Structure
REQ-032 ROUNDS, NIBBLES and the state encodings SHALL live in the shared header craft_defs.vh, included by both controller and datapath.
REQ-033 The block SHALL be a single module with no sub-module; it drives craft_key_register (en, CK0, r) from outside.

Verification
REQ-034 Reset, then start pulse with stall = 0 -> busy = 1 for 544 cycles; done = 1 on the next cycle only; busy = 0 afterwards.
REQ-035 Same run -> ck0 = 1 for exactly 16 cycles; r steps 0..31 every 16 cycles; key_sel = r mod 4; last_round high for exactly 16 cycles.
REQ-036 stall = 1 for 5 cycles at ROUND r = 7, nib = 9 -> r/nib hold at 7/9 and reg_en = 0 for 5 cycles; done is delayed by exactly 5 cycles (busy for 549 cycles).
REQ-037 start pulsed again at r = 12 -> ignored; the run completes unchanged with a single done pulse.
REQ-038 reset_n low at r = 20 -> immediately IDLE with all outputs 0; a new start then completes in 544 busy cycles.
REQ-039 start = 1 with stall = 1 in IDLE -> stays in IDLE; after stall drops with start held -> LOAD on that edge.

Source files
------------

// File: rtl/craft_serial_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// craft_serial_ctrl_pkg
// Shared definitions for the nibble-serial CRAFT controller: default round and
// nibble counts, the controller state encoding and a small decode helper.
// -----------------------------------------------------------------------------
package craft_serial_ctrl_pkg;

    // Default cipher geometry: 32 rounds over a 64-bit block of 16 nibbles.
    localparam int CRAFT_ROUNDS  = 32;
    localparam int CRAFT_NIBBLES = 16;

    // Controller phases. Only these five encodings are ever loaded into the
    // state register; anything else is steered back to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_e;

    // True for the phases in which the datapath is actively working.
    function automatic logic state_is_busy(input ctrl_state_e st);
        return (st == ST_LOAD) || (st == ST_ROUND) || (st == ST_OUT);
    endfunction

endpackage

// File: rtl/craft_serial_ctrl.sv
// -----------------------------------------------------------------------------
// craft_serial_ctrl
// Sequencer for a nibble-serial CRAFT encryption core. One run is:
//   LOAD  : NIBBLES cycles shifting plaintext/key in (ck0 = 1)
//   ROUND : ROUNDS x NIBBLES cycles, one nibble per cycle, r advancing per round
//   OUT   : NIBBLES cycles presenting ciphertext nibbles (out_valid = 1)
//   DONE  : single-cycle completion pulse, then back to IDLE
// The key register and state datapath are driven from outside using reg_en,
// ck0, r and key_sel.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   begin one encryption (honoured only in IDLE, when not stalled)
//   stall      in   freezes state, r and nib; forces reg_en/out_valid low
//   busy       out  high in LOAD, ROUND and OUT
//   done       out  one-cycle pulse after the last output nibble
//   reg_en     out  datapath / key register enable
//   ck0        out  key register load-select, high only in LOAD
//   r          out  round index 0..ROUNDS-1, zero-extended to 8 bits
//   nib        out  nibble index within the current phase
//   key_sel    out  tweakey selector, equal to r[1:0]
//   last_round out  high in the final round (no MixColumn/permutation)
//   out_valid  out  ciphertext nibble valid
// -----------------------------------------------------------------------------
module craft_serial_ctrl
    import craft_serial_ctrl_pkg::*;
#(
    parameter int ROUNDS  = CRAFT_ROUNDS,
    parameter int NIBBLES = CRAFT_NIBBLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stall,
    output logic       busy,
    output logic       done,
    output logic       reg_en,
    output logic       ck0,
    output logic [7:0] r,
    output logic [3:0] nib,
    output logic [1:0] key_sel,
    output logic       last_round,
    output logic       out_valid
);

    localparam logic [3:0] NIB_LAST   = 4'(NIBBLES - 1);
    localparam logic [7:0] ROUND_LAST = 8'(ROUNDS - 1);

    ctrl_state_e state_reg, state_next;
    logic [7:0]  r_reg,     r_next;
    logic [3:0]  nib_reg,   nib_next;

    logic nib_last;
    assign nib_last = (nib_reg == NIB_LAST);

    // State and counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            r_reg     <= 8'd0;
            nib_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            r_reg     <= r_next;
            nib_reg   <= nib_next;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        nib_next   = nib_reg;

        busy       = state_is_busy(state_reg);
        done       = 1'b0;
        ck0        = 1'b0;
        last_round = 1'b0;
        out_valid  = 1'b0;
        // Stall gates the enable but leaves the phase decodes alone, so
        // ck0/last_round/key_sel stay steady across a stall.
        reg_en     = state_is_busy(state_reg) && !stall;

        unique case (state_reg)
            ST_IDLE: begin
                if (start && !stall) begin
                    state_next = ST_LOAD;
                    r_next     = 8'd0;
                    nib_next   = 4'd0;
                end
            end

            ST_LOAD: begin
                ck0 = 1'b1;
                if (!stall) begin
                    if (nib_last) begin
                        nib_next   = 4'd0;
                        state_next = ST_ROUND;
                    end else begin
                        nib_next = nib_reg + 4'd1;
                    end
                end
            end

            ST_ROUND: begin
                last_round = (r_reg == ROUND_LAST);
                if (!stall) begin
                    if (nib_last) begin
                        nib_next = 4'd0;
                        // r stays at its final value through OUT.
                        if (r_reg == ROUND_LAST) begin
                            state_next = ST_OUT;
                        end else begin
                            r_next = r_reg + 8'd1;
                        end
                    end else begin
                        nib_next = nib_reg + 4'd1;
                    end
                end
            end

            ST_OUT: begin
                out_valid = !stall;
                if (!stall) begin
                    if (nib_last) begin
                        nib_next   = 4'd0;
                        state_next = ST_DONE;
                    end else begin
                        nib_next = nib_reg + 4'd1;
                    end
                end
            end

            ST_DONE: begin
                // Leaves unconditionally so a stall cannot stretch the pulse.
                done       = 1'b1;
                state_next = ST_IDLE;
                r_next     = 8'd0;
                nib_next   = 4'd0;
            end

            default: begin
                state_next = ST_IDLE;
                r_next     = 8'd0;
                nib_next   = 4'd0;
            end
        endcase
    end

    assign r       = r_reg;
    assign nib     = nib_reg;
    assign key_sel = r_reg[1:0];

endmodule
